// File: rtl/multiplier_fixedpoint_pipelined.sv
// Fixed-point Q(I).(F) multiplier with an elastic 3-stage valid/ready pipeline.
// Supports signed or unsigned operands, round-half-up or truncation, and
// saturation or wrap on overflow. One product per cycle when unstalled.
module multiplier_fixedpoint_pipelined #(
  parameter int INTEGER_BITWIDTH  = 4,
  parameter int FRACTION_BITWIDTH = 4,
  parameter int SIGNED            = 1,
  parameter int ROUND             = 1,
  parameter int SATURATE          = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [INTEGER_BITWIDTH+FRACTION_BITWIDTH-1:0] a,
  input  logic [INTEGER_BITWIDTH+FRACTION_BITWIDTH-1:0] b,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [INTEGER_BITWIDTH+FRACTION_BITWIDTH-1:0] q,
  output logic                                          overflow
);

  localparam int W   = INTEGER_BITWIDTH + FRACTION_BITWIDTH;
  localparam int F   = FRACTION_BITWIDTH;
  // Product is kept two bits wider than 2W so the unsigned case can be
  // handled as a signed multiply of zero-extended operands, and adding the
  // rounding term can never wrap.
  localparam int PW  = 2 * W + 2;
  localparam int RSH = (F > 0) ? F - 1 : 0;

  localparam logic signed [PW-1:0] ONE_V = {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] RND_V = ((ROUND != 0) && (F > 0)) ? (ONE_V <<< RSH) : {PW{1'b0}};
  localparam logic signed [PW-1:0] MAX_V = (SIGNED != 0) ? ((ONE_V <<< (W - 1)) - ONE_V)
                                                         : ((ONE_V <<< W) - ONE_V);
  localparam logic signed [PW-1:0] MIN_V = (SIGNED != 0) ? -(ONE_V <<< (W - 1)) : {PW{1'b0}};

  logic                 v0_r, v1_r, v2_r;
  logic [W-1:0]         a_r, b_r;
  logic signed [PW-1:0] prod_r;
  logic [W-1:0]         q_r;
  logic                 ovf_r;

  logic                 en0_s, en1_s, en2_s;
  logic signed [W:0]    a_x_s, b_x_s;
  logic signed [PW-1:0] prod_s, sum_s, res_s;
  logic [W-1:0]         q_s;
  logic                 ovf_s;

  // Stage enables: a stage loads when empty or when its contents move on.
  always_comb begin
    en2_s = ~v2_r | out_ready;
    en1_s = ~v1_r | en2_s;
    en0_s = ~v0_r | en1_s;
  end

  assign in_ready  = en0_s;
  assign out_valid = v2_r;
  assign q         = q_r;
  assign overflow  = ovf_r;

  // Operand extension to W+1 bits and full-precision product.
  always_comb begin
    a_x_s  = {((SIGNED != 0) ? a_r[W-1] : 1'b0), a_r};
    b_x_s  = {((SIGNED != 0) ? b_r[W-1] : 1'b0), b_r};
    prod_s = PW'(a_x_s) * PW'(b_x_s);
  end

  // Round, rescale by 2^F (floor), then range-check and saturate or wrap.
  always_comb begin
    sum_s = prod_r + RND_V;
    res_s = sum_s >>> F;
    q_s   = res_s[W-1:0];
    ovf_s = 1'b0;
    if (res_s > MAX_V) begin
      ovf_s = 1'b1;
      q_s   = (SATURATE != 0) ? MAX_V[W-1:0] : res_s[W-1:0];
    end else if (res_s < MIN_V) begin
      ovf_s = 1'b1;
      q_s   = (SATURATE != 0) ? MIN_V[W-1:0] : res_s[W-1:0];
    end else begin
      ovf_s = 1'b0;
      q_s   = res_s[W-1:0];
    end
  end

  // Stage 0: capture operands on input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r <= 1'b0;
      a_r  <= {W{1'b0}};
      b_r  <= {W{1'b0}};
    end else if (en0_s) begin
      v0_r <= in_valid;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end
    end
  end

  // Stage 1: register the full product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      prod_r <= {PW{1'b0}};
    end else if (en1_s) begin
      v1_r <= v0_r;
      if (v0_r) begin
        prod_r <= prod_s;
      end
    end
  end

  // Stage 2: register the rounded/saturated result; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r  <= 1'b0;
      q_r   <= {W{1'b0}};
      ovf_r <= 1'b0;
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        q_r   <= q_s;
        ovf_r <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_fixedpoint_pipelined.sv
// Self-checking bench: four Q4.4 instances (default, ROUND=0, SATURATE=0,
// SIGNED=0) share stimulus; an arithmetic reference model and an in-order
// scoreboard check every output transfer, plus hand-computed vectors.
module tb_multiplier_fixedpoint_pipelined;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] a, b;
  logic [3:0] ir, ov, of;
  logic [7:0] qv [4];

  int checks = 0;
  int errors = 0;

  logic [7:0] opa [4][64];
  logic [7:0] opb [4][64];
  int         wr [4];
  int         rd [4];
  bit         hold [4];
  logic [7:0] hq [4];
  logic       hof [4];

  always #5 clk = ~clk;

  multiplier_fixedpoint_pipelined #(.INTEGER_BITWIDTH(4), .FRACTION_BITWIDTH(4), .SIGNED(1), .ROUND(1), .SATURATE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .q(qv[0]), .overflow(of[0]));
  multiplier_fixedpoint_pipelined #(.INTEGER_BITWIDTH(4), .FRACTION_BITWIDTH(4), .SIGNED(1), .ROUND(0), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .q(qv[1]), .overflow(of[1]));
  multiplier_fixedpoint_pipelined #(.INTEGER_BITWIDTH(4), .FRACTION_BITWIDTH(4), .SIGNED(1), .ROUND(1), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .q(qv[2]), .overflow(of[2]));
  multiplier_fixedpoint_pipelined #(.INTEGER_BITWIDTH(4), .FRACTION_BITWIDTH(4), .SIGNED(0), .ROUND(1), .SATURATE(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
    .out_valid(ov[3]), .out_ready(out_ready), .q(qv[3]), .overflow(of[3]));

  // Reference: real-valued product scaled by 16, rounded/floored, then clamped or wrapped.
  function automatic logic [8:0] model(input logic [7:0] xa, input logic [7:0] xb, input int cfg);
    bit         sg, rnd, sat;
    longint     av, bv, p, r, mx, mn;
    logic [7:0] qq;
    logic       o;
    sg  = (cfg != 3);
    rnd = (cfg != 1);
    sat = (cfg != 2);
    av  = sg ? longint'($signed(xa)) : longint'(xa);
    bv  = sg ? longint'($signed(xb)) : longint'(xb);
    p   = av * bv;
    if (rnd) p = p + 64'sd8;
    r   = p >>> 4;
    mx  = sg ? 64'sd127 : 64'sd255;
    mn  = sg ? -64'sd128 : 64'sd0;
    if (r > mx) begin
      o = 1'b1; qq = sat ? mx[7:0] : r[7:0];
    end else if (r < mn) begin
      o = 1'b1; qq = sat ? mn[7:0] : r[7:0];
    end else begin
      o = 1'b0; qq = r[7:0];
    end
    return {o, qq};
  endfunction

  // Per-edge scoreboard: ordering, stall stability and in_ready rule.
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          wr[i] = 0; rd[i] = 0; hold[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (ir[i] !== !(((wr[i] - rd[i]) == 3) && !out_ready)) begin
            errors++;
            $display("FAIL in_ready_rule inst%0d got=%b occupancy=%0d out_ready=%b", i, ir[i], wr[i] - rd[i], out_ready);
          end
          if (hold[i]) begin
            checks++;
            if (ov[i] !== 1'b1 || qv[i] !== hq[i] || of[i] !== hof[i]) begin
              errors++;
              $display("FAIL stall_hold inst%0d got v=%b q=%h o=%b want v=1 q=%h o=%b", i, ov[i], qv[i], of[i], hq[i], hof[i]);
            end
          end
          if (ov[i] === 1'b1 && out_ready) begin
            checks++;
            if (rd[i] == wr[i]) begin
              errors++;
              $display("FAIL spurious_output inst%0d q=%h nothing outstanding", i, qv[i]);
            end else begin
              e = model(opa[i][rd[i] % 64], opb[i][rd[i] % 64], i);
              if ({of[i], qv[i]} !== e) begin
                errors++;
                $display("FAIL model inst%0d a=%h b=%h got o=%b q=%h want o=%b q=%h",
                         i, opa[i][rd[i] % 64], opb[i][rd[i] % 64], of[i], qv[i], e[8], e[7:0]);
              end
              rd[i]++;
            end
          end
          hold[i] = (ov[i] === 1'b1) && !out_ready;
          hq[i]   = qv[i];
          hof[i]  = of[i];
          if (in_valid && ir[i]) begin
            opa[i][wr[i] % 64] = a;
            opb[i][wr[i] % 64] = b;
            wr[i]++;
          end
        end
      end
    end
  endtask

  // Present one operand pair until accepted (bounded).
  task automatic send(input logic [7:0] xa, input logic [7:0] xb, input bit rnd_ready);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      in_valid = 1'b1; a = xa; b = xb;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (ir[0]) done = 1'b1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout a=%h b=%h got=not_accepted want=accepted", xa, xb);
    end
  endtask

  // Single transfer with out_ready high: check latency and hand-computed results.
  task automatic single(input logic [7:0] xa, input logic [7:0] xb, input logic [35:0] exp, input string nm);
    int lat;
    out_ready = 1'b1;
    send(xa, xb, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (ov[0] !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s_latency got=%0d want=3", nm, lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({of[i], qv[i]} !== exp[9*i +: 9]) begin
        errors++;
        $display("FAIL %s inst%0d got o=%b q=%h want o=%b q=%h", nm, i, of[i], qv[i], exp[9*i+8], exp[9*i +: 8]);
      end
    end
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00;
    fork
      monitor();
    join_none

    // Reset state
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || qv[i] !== 8'h00 || of[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d got v=%b q=%h o=%b want 0/00/0", i, ov[i], qv[i], of[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ir !== 4'hF) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1111", ir);
    end

    // Hand-computed vectors, {inst3, inst2, inst1, inst0} as {overflow, q}
    single(8'h18, 8'h20, {9'h030, 9'h030, 9'h030, 9'h030}, "mul_1p5x2");
    single(8'hE8, 8'h20, {9'h1FF, 9'h0D0, 9'h0D0, 9'h0D0}, "mul_neg1p5x2");
    single(8'h70, 8'h20, {9'h0E0, 9'h1E0, 9'h17F, 9'h17F}, "mul_14x2");
    single(8'h80, 8'h80, {9'h1FF, 9'h100, 9'h17F, 9'h17F}, "mul_min_min");
    single(8'h01, 8'h08, {9'h001, 9'h001, 9'h000, 9'h001}, "mul_round");
    single(8'hFF, 8'h10, {9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF}, "mul_ff_x1");
    single(8'hFF, 8'h20, {9'h1FF, 9'h0FE, 9'h0FE, 9'h0FE}, "mul_ff_x2");
    single(8'h00, 8'h55, {9'h000, 9'h000, 9'h000, 9'h000}, "mul_zero");

    // Back-to-back stream under random backpressure
    base = wr[0];
    for (int k = 0; k < 16; k++) begin
      send(8'(k * 37 + 5), 8'(8'hF0 + k * 11), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((rd[0] != wr[0] || ov !== 4'h0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((wr[0] - base) != 16 || rd[0] != wr[0]) begin
      errors++;
      $display("FAIL stream_drain got accepted=%0d outstanding=%0d want 16/0", wr[0] - base, wr[0] - rd[0]);
    end

    // Asynchronous reset with three results in flight
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b0);
    send(8'h55, 8'h66, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || qv[i] !== 8'h00 || of[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d got v=%b q=%h o=%b want 0/00/0", i, ov[i], qv[i], of[i]);
      end
    end
    #9 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ir !== 4'hF || ov !== 4'h0) begin
      errors++;
      $display("FAIL post_reset got ready=%b valid=%b want 1111/0000", ir, ov);
    end
    single(8'h18, 8'h20, {9'h030, 9'h030, 9'h030, 9'h030}, "after_reset");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
